tx_iq_feeder: RTL and testbench
===============================

TX_IQ_FEEDER -- requirements
Module: tx_iq_feeder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10; FIFO depth is 2^DEPTH_LOG2 32-bit words (1024).
REQ-002 Parameter AFULL_LEVEL, default 960; almost-full threshold in words.
REQ-003 clk  input  1  single clock for all logic; sole rising-edge domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_byte  input  8  host TX sample byte stream, already synchronous to clk.
REQ-006 in_valid  input  1  in_byte is accepted on each clk edge where high.
REQ-007 in_sof  input  1  qualified by in_valid; marks the first byte of a sample.
REQ-008 flush  input  1  synchronous FIFO and assembler clear, e.g. on PTT release.
REQ-009 tsiq_read_strobe  input  1  consumer read request, one word per high cycle.
REQ-010 tsiq_data  output  32  head word {I[15:0], Q[15:0]}, first-word-fall-through.
REQ-011 fifo_empty  output  1  high when the stored word count is 0.
REQ-012 fifo_afull  output  1  high when fifo_level >= AFULL_LEVEL; host back-pressure.
REQ-013 fifo_level  output  DEPTH_LOG2+1  stored word count, 0..2^DEPTH_LOG2.
REQ-014 overflow_cnt  output  16  count of dropped words, saturating.
REQ-015 underflow_cnt  output  16  count of strobes while empty, saturating.

Function
REQ-016 Assembler byte index 0..3, advancing on each accepted byte, wrapping from 3 to 0; byte order I[15:8], I[7:0], Q[15:8], Q[7:0].
REQ-017 in_valid with in_sof stores the byte as index 0 and discards any partial word; next byte is index 1.
REQ-018 On accepting index 3, the completed word is registered as a pending write, one cycle.
REQ-019 Pending write is stored at the next edge; fourth byte accepted at edge n -> word on tsiq_data and fifo_empty low after edge n+2, if FIFO was empty.
REQ-020 Pending write while full, with no same-cycle read: word dropped, overflow_cnt +1, FIFO unchanged.
REQ-021 Pending write while full, with same-cycle strobe: both occur, level unchanged, no overflow.
REQ-022 tsiq_data valid in the same cycle as tsiq_read_strobe; consumer samples it at that edge; next word appears after the edge.
REQ-023 tsiq_data = 32'h0000_0000 whenever fifo_empty is high.
REQ-024 Strobe while empty: pointers unchanged, underflow_cnt +1; a same-cycle pending write still stores (level 0 -> 1).
REQ-025 tsiq_data driven from registered state only; no combinational path from tsiq_read_strobe to tsiq_data.
REQ-026 Read and write pointers wrap modulo 2^DEPTH_LOG2; full at level 2^DEPTH_LOG2, empty at 0.
REQ-027 fifo_level, fifo_empty and fifo_afull update on the edge that changes occupancy; no extra lag.
REQ-028 Counters saturate at 16'hFFFF and never wrap.
REQ-029 flush has priority over same-cycle read, write and byte accept; it clears pointers, level, the pending write and the byte index.
REQ-030 flush does not clear the counters; a strobe during flush does not count as underflow; the in_byte in that cycle is discarded.

Reset
REQ-031 reset low clears pointers, fifo_level, byte index, pending write, overflow_cnt and underflow_cnt immediately, without waiting for clk.
REQ-032 During reset: tsiq_data=0, fifo_empty=1, fifo_afull=0.
REQ-033 Reset mid-word discards the partial word; first byte after release is index 0.
REQ-034 Storage-array contents need no reset; they are never visible while empty.

Verification
REQ-035 Bytes 12,34,AB,CD (in_sof on first), FIFO empty -> tsiq_data=32'h1234ABCD, fifo_empty=0 two edges after the 4th byte; one strobe -> level 0, tsiq_data=0.
REQ-036 Bytes 11,22 then in_sof with 55,66,77,88 -> exactly one word, 32'h55667788.
REQ-037 Write 1025 words with no reads -> level 1024, afull=1 from word 960, overflow_cnt=1; 1024 strobes return the words in order, no underflow.
REQ-038 FIFO full, pending write and strobe in the same cycle -> level stays 1024, overflow_cnt unchanged; 3 strobes on empty -> underflow_cnt=3, tsiq_data=0.
REQ-039 Level 500, flush with a same-cycle strobe and byte -> level 0, empty=1, counters unchanged; next sof word is stored normally.
REQ-040 Assert reset asynchronously between clk edges after 2 bytes of a word -> outputs clear before the next edge; counters 0; post-release 4-byte word assembles correctly.

Source files
------------

// File: rtl/tx_iq_feeder.sv
// TX IQ feeder: packs a host byte stream into {I,Q} words and buffers them in a
// first-word-fall-through FIFO with level, almost-full and drop/underrun counters.
module tx_iq_feeder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int AFULL_LEVEL = 960
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic                  flush,
    input  logic                  tsiq_read_strobe,
    output logic [31:0]           tsiq_data,
    output logic                  fifo_empty,
    output logic                  fifo_afull,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [15:0]           overflow_cnt,
    output logic [15:0]           underflow_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AFULL_LVL = (DEPTH_LOG2+1)'(AFULL_LEVEL);

    logic [1:0]            byte_idx, idx_eff;
    logic [23:0]           asm_hi;
    logic [31:0]           asm_word, pend_data;
    logic                  asm_done, pend_vld;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  full, do_wr, do_rd, ovf, unf;

    // sof forces this byte to slot 0, dropping any partial word
    assign idx_eff = in_sof ? 2'd0 : byte_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx <= '0;
            asm_done <= 1'b0;
            pend_vld <= 1'b0;
        end else if (flush) begin
            byte_idx <= '0;
            asm_done <= 1'b0;
            pend_vld <= 1'b0;
        end else begin
            asm_done <= in_valid && (idx_eff == 2'd3);
            pend_vld <= asm_done;
            if (in_valid) byte_idx <= idx_eff + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && !flush) begin
            case (idx_eff)
                2'd0:    asm_hi[23:16] <= in_byte;
                2'd1:    asm_hi[15:8]  <= in_byte;
                2'd2:    asm_hi[7:0]   <= in_byte;
                default: asm_word      <= {asm_hi, in_byte};
            endcase
        end
        if (asm_done) pend_data <= asm_word;
    end

    assign full       = (fifo_level == FULL_LVL);
    assign fifo_empty = (fifo_level == '0);
    assign fifo_afull = (fifo_level >= AFULL_LVL);

    // a read frees a slot in the same edge, so a full FIFO can still accept a write
    assign do_rd = tsiq_read_strobe && !fifo_empty && !flush;
    assign do_wr = pend_vld && !flush && (!full || tsiq_read_strobe);
    assign ovf   = pend_vld && !flush && full && !tsiq_read_strobe;
    assign unf   = tsiq_read_strobe && fifo_empty && !flush;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= pend_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            overflow_cnt  <= '0;
            underflow_cnt <= '0;
        end else begin
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + 1'b1;
                if (do_rd) rd_ptr <= rd_ptr + 1'b1;
                case ({do_wr, do_rd})
                    2'b10:   fifo_level <= fifo_level + 1'b1;
                    2'b01:   fifo_level <= fifo_level - 1'b1;
                    default: fifo_level <= fifo_level;
                endcase
            end
            if (ovf && overflow_cnt != 16'hFFFF)  overflow_cnt  <= overflow_cnt + 16'd1;
            if (unf && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

    // head word comes from the registered read pointer; stale storage is masked when empty
    assign tsiq_data = fifo_empty ? 32'h0000_0000 : mem[rd_ptr];

endmodule

// File: tb/tb_tx_iq_feeder.sv
// Bench for tx_iq_feeder: vector table of byte sequences plus hand-written
// sequences for fill/overflow, full read-write, underflow, flush and async reset.
module tb_tx_iq_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0, in_sof = 1'b0, flush = 1'b0, tsiq_read_strobe = 1'b0;
    logic [31:0] tsiq_data;
    logic        fifo_empty, fifo_afull;
    logic [10:0] fifo_level;
    logic [15:0] overflow_cnt, underflow_cnt;

    tx_iq_feeder dut (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_sof(in_sof),
        .flush(flush), .tsiq_read_strobe(tsiq_read_strobe), .tsiq_data(tsiq_data),
        .fifo_empty(fifo_empty), .fifo_afull(fifo_afull), .fifo_level(fifo_level),
        .overflow_cnt(overflow_cnt), .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [31:0] sb[$];

    typedef struct {
        int          n;
        logic [47:0] bytes;
        logic [5:0]  sof;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sof);
        in_byte = b; in_sof = sof; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic sof);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], sof && (k == 0));
    endtask

    task automatic strobe_pop(input string name);
        logic [31:0] e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty, got %h expected no data", name, tsiq_data);
        end else begin
            e = sb.pop_front();
            check(name, tsiq_data, e);
        end
        tsiq_read_strobe = 1'b1;
        @(posedge clk); #1;
        tsiq_read_strobe = 1'b0;
    endtask

    function automatic logic [31:0] wpat(input int i);
        logic [15:0] v;
        v = 16'(i);
        return {v, ~v};
    endfunction

    initial begin
        vecs[0] = '{4, 48'h1234ABCD_0000, 6'b000001, 32'h1234ABCD};
        vecs[1] = '{6, 48'h11225566_7788, 6'b000100, 32'h55667788};
        vecs[2] = '{4, 48'hDEADBEEF_0000, 6'b000000, 32'hDEADBEEF};
        vecs[3] = '{5, 48'h99A1B2C3_D400, 6'b000010, 32'hA1B2C3D4};
        vecs[4] = '{4, 48'h00FF00FF_0000, 6'b000001, 32'h00FF00FF};

        // reset state
        #12;
        check("rst_data", tsiq_data, 32'h0);
        check("rst_empty", fifo_empty, 1);
        check("rst_afull", fifo_afull, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow_cnt, 0);
        check("rst_unf", underflow_cnt, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // two-edge write latency from the fourth byte
        send_word(32'h1234ABCD, 1'b1);
        sb.push_back(32'h1234ABCD);
        check("lat_n", fifo_empty, 1);
        idle(1);
        check("lat_n1", fifo_empty, 1);
        idle(1);
        check("lat_n2_empty", fifo_empty, 0);
        check("lat_n2_level", fifo_level, 1);
        strobe_pop("lat_data");
        check("lat_after_level", fifo_level, 0);
        check("lat_after_data", tsiq_data, 32'h0);

        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < vecs[v].n; k++)
                send_byte(vecs[v].bytes[47-8*k -: 8], vecs[v].sof[k]);
            sb.push_back(vecs[v].exp);
            idle(2);
            check($sformatf("vec%0d_level", v), fifo_level, 1);
            strobe_pop($sformatf("vec%0d_data", v));
            check($sformatf("vec%0d_empty", v), fifo_empty, 1);
        end

        // fill to afull, full, then one dropped word
        for (int i = 0; i < 959; i++) begin
            send_word(wpat(i), i == 0);
            sb.push_back(wpat(i));
        end
        idle(3);
        check("fill959_level", fifo_level, 959);
        check("fill959_afull", fifo_afull, 0);
        send_word(wpat(959), 1'b0);
        sb.push_back(wpat(959));
        idle(3);
        check("fill960_afull", fifo_afull, 1);
        for (int i = 960; i < 1024; i++) begin
            send_word(wpat(i), 1'b0);
            sb.push_back(wpat(i));
        end
        idle(3);
        check("full_level", fifo_level, 1024);
        check("full_ovf0", overflow_cnt, 0);
        send_word(wpat(1024), 1'b0);
        idle(3);
        check("drop_ovf", overflow_cnt, 1);
        check("drop_level", fifo_level, 1024);

        // full with pending write and strobe on the same edge
        send_word(32'hFEEDFACE, 1'b0);
        idle(1);
        strobe_pop("fullrw_data");
        sb.push_back(32'hFEEDFACE);
        check("fullrw_level", fifo_level, 1024);
        check("fullrw_ovf", overflow_cnt, 1);
        for (int i = 0; i < 1024; i++) strobe_pop("drain");
        check("drain_level", fifo_level, 0);
        check("drain_empty", fifo_empty, 1);
        check("drain_unf", underflow_cnt, 0);
        check("drain_afull", fifo_afull, 0);

        tsiq_read_strobe = 1'b1;
        idle(3);
        tsiq_read_strobe = 1'b0;
        check("unf_cnt", underflow_cnt, 3);
        check("unf_data", tsiq_data, 32'h0);
        check("unf_level", fifo_level, 0);

        // flush beats a same-cycle strobe and byte
        for (int i = 0; i < 500; i++) send_word(wpat(i), i == 0);
        idle(3);
        check("pre_flush_level", fifo_level, 500);
        flush = 1'b1; tsiq_read_strobe = 1'b1; in_valid = 1'b1; in_sof = 1'b1; in_byte = 8'h77;
        @(posedge clk); #1;
        flush = 1'b0; tsiq_read_strobe = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        check("flush_level", fifo_level, 0);
        check("flush_empty", fifo_empty, 1);
        check("flush_data", tsiq_data, 32'h0);
        check("flush_ovf", overflow_cnt, 1);
        check("flush_unf", underflow_cnt, 3);
        send_word(32'hCAFEF00D, 1'b1);
        sb.push_back(32'hCAFEF00D);
        idle(2);
        check("postflush_level", fifo_level, 1);
        strobe_pop("postflush_data");

        // async reset mid-word, between clock edges
        send_word(32'h0BADC0DE, 1'b1);
        idle(2);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b0);
        #3 reset = 1'b0;
        #1;
        check("arst_level", fifo_level, 0);
        check("arst_empty", fifo_empty, 1);
        check("arst_data", tsiq_data, 32'h0);
        check("arst_afull", fifo_afull, 0);
        check("arst_ovf", overflow_cnt, 0);
        check("arst_unf", underflow_cnt, 0);
        sb.delete();
        @(posedge clk); #4;
        reset = 1'b1;
        @(posedge clk); #1;
        send_word(32'hA1B2C3D4, 1'b0);
        sb.push_back(32'hA1B2C3D4);
        idle(2);
        check("postrst_level", fifo_level, 1);
        strobe_pop("postrst_data");
        check("postrst_empty", fifo_empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
